// File: rtl/pwm_bank_pkg.sv
// pwm_bank_pkg
// Shared constants for the PWM bank peripheral: Avalon-MM word addresses
// of the register map and bit positions inside CTRL and STATUS.
package pwm_bank_pkg;

  localparam logic [4:0] ADDR_CTRL     = 5'd0;
  localparam logic [4:0] ADDR_PERIOD   = 5'd1;
  localparam logic [4:0] ADDR_PRESCALE = 5'd2;
  localparam logic [4:0] ADDR_POLARITY = 5'd3;
  localparam logic [4:0] ADDR_STATUS   = 5'd4;
  localparam logic [4:0] ADDR_DUTY0    = 5'd8;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  localparam int STATUS_WRAP_BIT = 0;

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel
// One PWM output: double-buffered duty register, compare against the shared
// period counter, polarity inversion and the output flop.
//   clk, reset_n : clock, asynchronous active-low reset
//   en           : bank enable; when low the output drives the inactive level
//   load         : copy duty shadow into the active copy this cycle
//   duty_we      : bus write strobe for this channel's duty shadow
//   wdata        : duty value from the bus (already truncated to CNT_W)
//   cnt_p0       : shared period counter
//   pol          : 1 = inverted output
//   duty_sh      : shadow value, for bus readback
//   pwm          : registered PWM output
module pwm_channel #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic             duty_we,
  input  logic [CNT_W-1:0] wdata,
  input  logic [CNT_W-1:0] cnt_p0,
  input  logic             pol,
  output logic [CNT_W-1:0] duty_sh,
  output logic             pwm
);

  logic [CNT_W-1:0] duty_act;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty_sh  <= '0;
      duty_act <= '0;
      pwm      <= 1'b0;
    end else begin
      if (duty_we) duty_sh <= wdata;
      // A shadow write coinciding with a load is picked up at the next load.
      if (load) duty_act <= duty_sh;
      // ---- stage p0 (counter state) -> p1 (registered output) ----
      pwm <= en ? ((cnt_p0 < duty_act) ^ pol) : pol;
    end
  end

endmodule

// File: rtl/pwm_bank_avmm.sv
// pwm_bank_avmm
// Multi-channel edge-aligned PWM bank with an Avalon-MM slave port.
// One prescaler and one period counter are shared by all channels; PERIOD
// and DUTY writes land in shadow registers and are copied to the active
// registers on each period wrap or continuously while disabled.
//   clk, reset_n   : clock, asynchronous active-low reset
//   avs_address    : word address
//   avs_write      : write strobe, avs_writedata is the write data
//   avs_read       : read strobe, avs_readdata valid one cycle later
//   irq            : level interrupt, WRAP & IRQ_EN
//   pwm_export     : registered PWM outputs
module pwm_bank_avmm
  import pwm_bank_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int CNT_W    = 16,
  parameter int PRESC_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [4:0]          avs_address,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  input  logic                avs_read,
  output logic [31:0]         avs_readdata,
  output logic                irq,
  output logic [CHANNELS-1:0] pwm_export
);

  logic                en;
  logic                irq_en;
  logic [CNT_W-1:0]    period_sh;
  logic [CNT_W-1:0]    period_act;
  logic [PRESC_W-1:0]  presc;
  logic [CHANNELS-1:0] polarity;
  logic                wrap_sts;
  logic [PRESC_W-1:0]  psc_p0;
  logic [CNT_W-1:0]    cnt_p0;

  logic                tick;
  logic                wrap_evt;
  logic                load_act;
  logic                wr_ctrl, wr_period, wr_presc, wr_pol, wr_status;
  logic [CHANNELS-1:0] duty_we;
  logic [CNT_W-1:0]    duty_sh [CHANNELS];
  logic [31:0]         rd_mux;
  logic                unused_wdata;

  // Upper write-data bits beyond each field are intentionally dropped.
  assign unused_wdata = ^avs_writedata;

  assign wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
  assign wr_period = avs_write && (avs_address == ADDR_PERIOD);
  assign wr_presc  = avs_write && (avs_address == ADDR_PRESCALE);
  assign wr_pol    = avs_write && (avs_address == ADDR_POLARITY);
  assign wr_status = avs_write && (avs_address == ADDR_STATUS);

  assign tick     = en && (psc_p0 == presc);
  assign wrap_evt = tick && (cnt_p0 == period_act);
  assign load_act = !en || wrap_evt;

  assign irq = wrap_sts & irq_en;

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_CTRL: begin
        rd_mux[CTRL_EN_BIT]     = en;
        rd_mux[CTRL_IRQ_EN_BIT] = irq_en;
      end
      ADDR_PERIOD:   rd_mux[CNT_W-1:0]    = period_sh;
      ADDR_PRESCALE: rd_mux[PRESC_W-1:0]  = presc;
      ADDR_POLARITY: rd_mux[CHANNELS-1:0] = polarity;
      ADDR_STATUS:   rd_mux[STATUS_WRAP_BIT] = wrap_sts;
      default: ;
    endcase
    for (int i = 0; i < CHANNELS; i++) begin
      if (avs_address == ADDR_DUTY0 + 5'(i)) rd_mux[CNT_W-1:0] = duty_sh[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en           <= 1'b0;
      irq_en       <= 1'b0;
      period_sh    <= '1;
      period_act   <= '1;
      presc        <= '0;
      polarity     <= '0;
      wrap_sts     <= 1'b0;
      psc_p0       <= '0;
      cnt_p0       <= '0;
      avs_readdata <= '0;
    end else begin
      if (wr_ctrl) begin
        en     <= avs_writedata[CTRL_EN_BIT];
        irq_en <= avs_writedata[CTRL_IRQ_EN_BIT];
      end
      if (wr_period) period_sh <= avs_writedata[CNT_W-1:0];
      if (wr_presc)  presc     <= avs_writedata[PRESC_W-1:0];
      if (wr_pol)    polarity  <= avs_writedata[CHANNELS-1:0];
      if (load_act)  period_act <= period_sh;

      // A wrap in the same cycle as a software clear keeps WRAP set.
      if (wrap_evt) wrap_sts <= 1'b1;
      else if (wr_status && avs_writedata[STATUS_WRAP_BIT]) wrap_sts <= 1'b0;

      // ---- stage p0: prescaler and period counter ----
      if (!en) begin
        psc_p0 <= '0;
        cnt_p0 <= '0;
      end else begin
        psc_p0 <= tick ? '0 : psc_p0 + 1'b1;
        if (tick) cnt_p0 <= (cnt_p0 == period_act) ? '0 : cnt_p0 + 1'b1;
      end

      if (avs_read) avs_readdata <= rd_mux;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign duty_we[g] = avs_write && (avs_address == ADDR_DUTY0 + 5'(g));

    pwm_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .load    (load_act),
      .duty_we (duty_we[g]),
      .wdata   (avs_writedata[CNT_W-1:0]),
      .cnt_p0  (cnt_p0),
      .pol     (polarity[g]),
      .duty_sh (duty_sh[g]),
      .pwm     (pwm_export[g])
    );
  end

endmodule

// File: tb/tb_pwm_bank_avmm.sv
// tb_pwm_bank_avmm
// Directed bench for pwm_bank_avmm (CHANNELS=8, CNT_W=16, PRESC_W=16):
// register table, waveform sequences, double-buffering corners, irq and
// asynchronous reset.
module tb_pwm_bank_avmm;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        irq;
  logic [7:0]  pwm_export;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_bank_avmm #(
    .CHANNELS (8),
    .CNT_W    (16),
    .PRESC_W  (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .irq           (irq),
    .pwm_export    (pwm_export)
  );

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  localparam int NRST = 8;
  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read    = 1'b0;
    d           = avs_readdata;
  endtask

  task automatic run_vecs(input int n);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, d);
      chk($sformatf("reg_vec%0d_addr%0d", i, vecs[i].addr), d, vecs[i].exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic        model_wrap;
    int          c;

    // reset-value reads first, then write/readback with truncation
    vecs[0]  = '{1'b0, 5'd0,  32'h0,        32'h0};
    vecs[1]  = '{1'b0, 5'd1,  32'h0,        32'h0000_FFFF};
    vecs[2]  = '{1'b0, 5'd2,  32'h0,        32'h0};
    vecs[3]  = '{1'b0, 5'd3,  32'h0,        32'h0};
    vecs[4]  = '{1'b0, 5'd4,  32'h0,        32'h0};
    vecs[5]  = '{1'b0, 5'd8,  32'h0,        32'h0};
    vecs[6]  = '{1'b0, 5'd15, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, 5'd5,  32'h0,        32'h0};
    vecs[8]  = '{1'b1, 5'd0,  32'hFFFF_FFFC, 32'h0};
    vecs[9]  = '{1'b1, 5'd1,  32'h0001_2345, 32'h0000_2345};
    vecs[10] = '{1'b1, 5'd2,  32'h000A_BCDE, 32'h0000_BCDE};
    vecs[11] = '{1'b1, 5'd3,  32'hFFFF_FF55, 32'h0000_0055};
    vecs[12] = '{1'b1, 5'd15, 32'h0001_FFFF, 32'h0000_FFFF};
    vecs[13] = '{1'b1, 5'd5,  32'h0000_1234, 32'h0};
    vecs[14] = '{1'b1, 5'd16, 32'h0000_1234, 32'h0};
    vecs[15] = '{1'b1, 5'd4,  32'hFFFF_FFFF, 32'h0};

    repeat (3) @(negedge clk);
    chk("rst_pwm_held", {24'h0, pwm_export}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_pwm", {24'h0, pwm_export}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_readdata", avs_readdata, 32'h0);

    run_vecs(NVEC);

    // restore what the table changed, set up channels 0/1
    wr(5'd3, 32'h0);
    wr(5'd15, 32'h0);
    wr(5'd2, 32'h0);
    wr(5'd1, 32'd9);
    wr(5'd8, 32'd3);
    wr(5'd9, 32'd2);
    wr(5'd0, 32'h1);

    // edge k = k-th clock after EN lands; cnt in cycle before edge k is (k-1)%10.
    // DUTY1 2->8 lands mid-period (edge 35), applies at the wrap edge 40.
    // DUTY0 3->5 lands on the wrap edge 50 itself, so applies only at edge 60.
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      avs_write = 1'b0;
      chk($sformatf("wave_ch0_k%0d", k), {31'h0, pwm_export[0]},
          {31'h0, (((k - 1) % 10) < ((k >= 61) ? 5 : 3))});
      chk($sformatf("wave_ch1_k%0d", k), {31'h0, pwm_export[1]},
          {31'h0, (((k - 1) % 10) < ((k >= 41) ? 8 : 2))});
      if (k == 34) begin
        avs_address = 5'd9; avs_writedata = 32'd8; avs_write = 1'b1;
      end
      if (k == 49) begin
        avs_address = 5'd8; avs_writedata = 32'd5; avs_write = 1'b1;
      end
    end
    @(negedge clk);
    avs_write = 1'b0;
    rd(5'd9, d);
    chk("duty1_readback", d, 32'd8);

    // zero duty inverted, and duty beyond period
    wr(5'd10, 32'd0);
    wr(5'd11, 32'd15);
    wr(5'd3, 32'h4);
    repeat (12) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("pol_ch2_k%0d", k), {31'h0, pwm_export[2]}, 32'h1);
      chk($sformatf("full_ch3_k%0d", k), {31'h0, pwm_export[3]}, 32'h1);
      chk($sformatf("idle_ch7_4_k%0d", k), {28'h0, pwm_export[7:4]}, 32'h0);
    end

    // prescaled period of 20 cycles with interrupt
    wr(5'd0, 32'h0);
    wr(5'd2, 32'd3);
    wr(5'd1, 32'd4);
    wr(5'd4, 32'h1);
    rd(5'd4, d);
    chk("status_cleared", d, 32'h0);
    chk("irq_idle", {31'h0, irq}, 32'h0);
    wr(5'd0, 32'h3);
    model_wrap = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      avs_write = 1'b0;
      if (k % 20 == 0) model_wrap = 1'b1;
      else if (k - 1 == 25 || k - 1 == 44 || k - 1 == 59) model_wrap = 1'b0;
      chk($sformatf("irq_k%0d", k), {31'h0, irq}, {31'h0, model_wrap});
      chk($sformatf("ch0_full_k%0d", k), {31'h0, pwm_export[0]}, 32'h1);
      if (k == 25 || k == 44 || k == 59) begin
        avs_address = 5'd4; avs_writedata = 32'h1; avs_write = 1'b1;
      end
    end
    @(negedge clk);
    avs_write = 1'b0;
    rd(5'd4, d);
    chk("wrap_set_wins", d, 32'h1);

    // asynchronous reset in the middle of a period
    repeat (7) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async_rst_pwm", {24'h0, pwm_export}, 32'h0);
    chk("async_rst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    run_vecs(NRST);
    c = 0;
    repeat (25) begin
      @(negedge clk);
      if (pwm_export !== 8'h0) c++;
    end
    chk("post_rst_idle_cycles", c, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
